sweep_acq_ctrl: RTL
===================

Name: sweep_acq_ctrl

Overview:
- Parametrised successor to the single-mask/two-APD sweep controller.
- Steps a modulator mask code through N points, one point per sync + vSync-rise event.
- Per point: clears the external accumulators, waits a delay, gates accumulation for a window, latches, then stores mask code plus N_CH channel counts into an internal buffer.
- After the last point, hands off to the Tx path and exposes a read port for readout.
- Adds multi-channel width, configurable depth, step size and triangle sweep mode.

Parameters:
N_CH, 2, number of APD count channels
CW, 32, bits per channel count
AW, 14, buffer address width; DEPTH = 2**AW
MW, 8, mask code width
MASK_SCALE, 2073600, multiplier applied to mask code for mask_out
GAP_CYCLES, 5, settle cycles after STORE before re-arming
TIMEOUT_CYCLES, 100000000, sync watchdog limit (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  start sweep (level; sampled in IDLE only)
sync  in  1  external sync qualifier
vsync  in  1  raw vSync; rising edge detected internally
mode  in  2  0 fixed, 1 ramp-up, 2 ramp-down, 3 triangle
mask_fixed  in  MW  mask code for mode 0; start code for modes 1-3
mask_step  in  MW  increment per point (0 treated as 1)
data_points  in  16  points per sweep; clamped to DEPTH
delay_cycles  in  32  cycles from CLR exit to acc_en
width_cycles  in  32  acc_en high time (0 treated as 1)
apd_counts  in  N_CH*CW  channel counts, ch0 in LSBs
acc_sclr  out  1  accumulator synchronous clear
acc_en  out  1  accumulator enable; also trigger_out
trigger_out  out  1  copy of acc_en
acc_latch  out  1  one-cycle latch strobe
mask_code  out  MW  current mask code
mask_out  out  32  registered mask_code*MASK_SCALE, truncated to 32 bits
tx_start  out  1  one-cycle Tx request
tx_ready  in  1  Tx done
rd_addr  in  AW  readout address
rd_mask  out  MW  stored mask code, 1-cycle latency
rd_data  out  N_CH*CW  stored counts, 1-cycle latency
busy  out  1  high outside IDLE
pt_count  out  16  points stored this sweep
err_timeout  out  1  watchdog abort flag (0 when feature absent)

Behaviour:
- Reset: all outputs 0.
  - State IDLE, pt_count 0, write pointer 0, mask_code 0.
  - Buffer contents are not cleared.
  - Reset mid-sweep aborts immediately; no tx_start is issued.
- vsync_rise = vsync & ~vsync_d, with one register stage.
- IDLE:
  - On start: load mask_code = mask_fixed, clear pt_count, write pointer and err_timeout, set direction up, go to ARM.
  - start while busy is ignored.
- ARM:
  - If pt_count >= min(data_points, DEPTH), go to TX. data_points = 0 therefore goes straight to TX.
  - Else, on sync & vsync_rise, go to CLR.
- CLR: acc_sclr = 1; on the next vsync_rise, drop acc_sclr and go to DELAY.
- DELAY: counts exactly delay_cycles cycles, then acc_en = 1 and go to ACQ.
- ACQ: acc_en stays high exactly max(width_cycles, 1) cycles, then go to LATCH.
- LATCH: one cycle with acc_en = 0, acc_sclr = 1, acc_latch = 1.
- STORE: one cycle.
  - Write {mask_code, apd_counts} at the write pointer, sampling apd_counts in this cycle.
  - Increment pt_count and the write pointer.
- GAP: GAP_CYCLES cycles, then update mask_code and go to ARM.
  - Mode 0: unchanged.
  - Mode 1: +step, wraps modulo 2**MW.
  - Mode 2: -step, wraps modulo 2**MW.
  - Mode 3: +step while direction is up. If the sum would exceed 2**MW-1, saturate at the max and set direction down. Mirror at 0.
- TX: pulse tx_start for one cycle, then wait for tx_ready (ignored in the pulse cycle), then go to IDLE.
- Read port:
  - Independent of writes, 1-cycle latency.
  - Reading the address written in the same cycle returns the old data.

Optional Feature:
- Macro ACQ_TIMEOUT_EN.
- When defined:
  - A counter runs in ARM and CLR and resets on every state change.
  - When it reaches TIMEOUT_CYCLES: set err_timeout (sticky until next start), drop acc_sclr, go to TX with the partial pt_count.
- When not defined: no counter, and err_timeout is tied to 0.

Decomposition:
- Package sweep_acq_pkg holds:
  - the state enum;
  - the mode encodings (MODE_FIXED, MODE_RAMP_UP, MODE_RAMP_DN, MODE_TRI);
  - the default MASK_SCALE.
- One sub-module, sweep_acq_buf: a simple dual-port RAM, DEPTH x (MW + N_CH*CW), with registered read.

Test Plan:
- Mode 1, mask_fixed = 10, step = 3, data_points = 4, delay = 2, width = 4 -> stored codes 10, 13, 16, 19; acc_en high exactly 4 cycles per point; a single tx_start after point 4.
- Mode 3, step = 100, start = 200, MW = 8, 4 points -> codes 200, 255, 155, 55.
- data_points = 0 with start -> tx_start one cycle after ARM entry; no writes.
- sync held low with vsync toggling -> stays in ARM; raising sync -> CLR on the next vsync rise only.
- rst asserted during ACQ -> acc_en, acc_sclr, busy and tx_start are 0 the next cycle; rd_data at addresses already written is still intact.
- ACQ_TIMEOUT_EN, TIMEOUT_CYCLES = 50, no vsync after 2 points -> err_timeout = 1, tx_start pulse, pt_count = 2.

Source files
------------

// File: rtl/sweep_acq_pkg.sv
// Shared types and constants for the sweep acquisition controller:
// FSM state encoding, sweep mode codes and the default mask scale.
package sweep_acq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_CLR,
    ST_DELAY,
    ST_ACQ,
    ST_LATCH,
    ST_STORE,
    ST_GAP,
    ST_TX_PULSE,
    ST_TX_WAIT
  } state_t;

  localparam logic [1:0] MODE_FIXED   = 2'd0;
  localparam logic [1:0] MODE_RAMP_UP = 2'd1;
  localparam logic [1:0] MODE_RAMP_DN = 2'd2;
  localparam logic [1:0] MODE_TRI     = 2'd3;

  localparam int unsigned DEFAULT_MASK_SCALE = 32'd2073600;

endpackage

// File: rtl/sweep_acq_buf.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered read. A same-address read during a write returns the old word.
module sweep_acq_buf
  import sweep_acq_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 72
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Only the output register is reset; stored samples survive a reset.
  always_ff @(posedge clk) begin
    if (rst) rd <= '0;
    else     rd <= mem[ra];
  end

endmodule

// File: rtl/sweep_acq_ctrl.sv
// Sweep acquisition controller: steps a mask code through N points, gates the
// external accumulators per point and buffers the results. Optional sync
// watchdog is compiled in with the ACQ_TIMEOUT_EN macro.
module sweep_acq_ctrl
  import sweep_acq_pkg::*;
#(
  parameter int          N_CH           = 2,
  parameter int          CW             = 32,
  parameter int          AW             = 14,
  parameter int          MW             = 8,
  parameter int unsigned MASK_SCALE     = DEFAULT_MASK_SCALE,
  parameter int          GAP_CYCLES     = 5,
  parameter int          TIMEOUT_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sync,
  input  logic               vsync,
  input  logic [1:0]         mode,
  input  logic [MW-1:0]      mask_fixed,
  input  logic [MW-1:0]      mask_step,
  input  logic [15:0]        data_points,
  input  logic [31:0]        delay_cycles,
  input  logic [31:0]        width_cycles,
  input  logic [N_CH*CW-1:0] apd_counts,
  output logic               acc_sclr,
  output logic               acc_en,
  output logic               trigger_out,
  output logic               acc_latch,
  output logic [MW-1:0]      mask_code,
  output logic [31:0]        mask_out,
  output logic               tx_start,
  input  logic               tx_ready,
  input  logic [AW-1:0]      rd_addr,
  output logic [MW-1:0]      rd_mask,
  output logic [N_CH*CW-1:0] rd_data,
  output logic               busy,
  output logic [15:0]        pt_count,
  output logic               err_timeout
);

  localparam int          DW       = MW + N_CH*CW;
  localparam logic [16:0] DEPTH_L  = 17'(1 << AW);
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_t        state_reg, state_next;
  logic [31:0]   cnt_reg;
  logic          vsync_d_reg;
  logic [MW-1:0] mask_code_reg;
  logic          dir_up_reg;
  logic [15:0]   pt_count_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [31:0]   mask_out_reg;

  logic          vsync_rise;
  logic [16:0]   pt_limit;
  logic          pt_done;
  logic [31:0]   width_eff;
  logic [MW-1:0] step_eff, mask_upd;
  logic [MW:0]   sum_up;
  logic          dir_upd;
  logic          we;
  logic [DW-1:0] wr_data, rd_word;

  assign vsync_rise = vsync & ~vsync_d_reg;
  assign pt_limit   = ({1'b0, data_points} > DEPTH_L) ? DEPTH_L : {1'b0, data_points};
  assign pt_done    = ({1'b0, pt_count_reg} >= pt_limit);
  assign width_eff  = (width_cycles == 32'd0) ? 32'd1 : width_cycles;
  assign step_eff   = (mask_step == '0) ? {{(MW-1){1'b0}}, 1'b1} : mask_step;
  assign sum_up     = {1'b0, mask_code_reg} + {1'b0, step_eff};

`ifdef ACQ_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  logic [31:0] to_cnt_reg;
  logic        err_reg;
  logic        timeout_hit;
  assign timeout_hit = ((state_reg == ST_ARM) || (state_reg == ST_CLR)) && (to_cnt_reg == TO_LAST);
  assign err_timeout = err_reg;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start) state_next = ST_ARM;
      ST_ARM: begin
        if (pt_done)                 state_next = ST_TX_PULSE;
        else if (sync && vsync_rise) state_next = ST_CLR;
      end
      ST_CLR:      if (vsync_rise) state_next = (delay_cycles == 32'd0) ? ST_ACQ : ST_DELAY;
      ST_DELAY:    if (cnt_reg == delay_cycles - 32'd1) state_next = ST_ACQ;
      ST_ACQ:      if (cnt_reg == width_eff - 32'd1) state_next = ST_LATCH;
      ST_LATCH:    state_next = ST_STORE;
      ST_STORE:    state_next = ST_GAP;
      ST_GAP:      if (cnt_reg >= GAP_LAST) state_next = ST_ARM;
      ST_TX_PULSE: state_next = ST_TX_WAIT;
      ST_TX_WAIT:  if (tx_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
`ifdef ACQ_TIMEOUT_EN
    // Watchdog only fires when the state would otherwise keep waiting.
    if (timeout_hit && (state_next == state_reg)) state_next = ST_TX_PULSE;
`endif
  end

  always_comb begin
    acc_sclr  = (state_reg == ST_CLR) || (state_reg == ST_LATCH);
    acc_en    = (state_reg == ST_ACQ);
    acc_latch = (state_reg == ST_LATCH);
    tx_start  = (state_reg == ST_TX_PULSE);
    busy      = (state_reg != ST_IDLE);
  end

  always_comb begin
    mask_upd = mask_code_reg;
    dir_upd  = dir_up_reg;
    case (mode)
      MODE_RAMP_UP: mask_upd = sum_up[MW-1:0];
      MODE_RAMP_DN: mask_upd = mask_code_reg - step_eff;
      MODE_TRI: begin
        if (dir_up_reg) begin
          if (sum_up[MW]) begin
            mask_upd = '1;
            dir_upd  = 1'b0;
          end else begin
            mask_upd = sum_up[MW-1:0];
          end
        end else if (mask_code_reg < step_eff) begin
          mask_upd = '0;
          dir_upd  = 1'b1;
        end else begin
          mask_upd = mask_code_reg - step_eff;
        end
      end
      default: mask_upd = mask_code_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_reg   <= 1'b0;
      cnt_reg       <= '0;
      mask_code_reg <= '0;
      dir_up_reg    <= 1'b1;
      pt_count_reg  <= '0;
      wr_ptr_reg    <= '0;
      mask_out_reg  <= '0;
    end else begin
      vsync_d_reg  <= vsync;
      cnt_reg      <= (state_next != state_reg) ? 32'd0 : cnt_reg + 32'd1;
      mask_out_reg <= 32'(32'(mask_code_reg) * 32'(MASK_SCALE));
      if (state_reg == ST_IDLE && start) begin
        mask_code_reg <= mask_fixed;
        dir_up_reg    <= 1'b1;
        pt_count_reg  <= '0;
        wr_ptr_reg    <= '0;
      end
      if (state_reg == ST_STORE) begin
        pt_count_reg <= pt_count_reg + 16'd1;
        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
      end
      if (state_reg == ST_GAP && state_next == ST_ARM) begin
        mask_code_reg <= mask_upd;
        dir_up_reg    <= dir_upd;
      end
    end
  end

`ifdef ACQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_next != state_reg)                             to_cnt_reg <= '0;
      else if (state_reg == ST_ARM || state_reg == ST_CLR)     to_cnt_reg <= to_cnt_reg + 32'd1;
      else                                                     to_cnt_reg <= '0;
      if (state_reg == ST_IDLE && start) err_reg <= 1'b0;
      else if (timeout_hit && state_next == ST_TX_PULSE)       err_reg <= 1'b1;
    end
  end
`endif

  assign we = (state_reg == ST_STORE) && !rst;
  assign wr_data[DW-1 -: MW] = mask_code_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_lane
      assign wr_data[gi*CW +: CW] = apd_counts[gi*CW +: CW];
      assign rd_data[gi*CW +: CW] = rd_word[gi*CW +: CW];
    end
  endgenerate

  sweep_acq_buf #(.AW(AW), .DW(DW)) u_buf (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wr_ptr_reg),
    .wd  (wr_data),
    .ra  (rd_addr),
    .rd  (rd_word)
  );

  assign rd_mask     = rd_word[DW-1 -: MW];
  assign mask_code   = mask_code_reg;
  assign mask_out    = mask_out_reg;
  assign trigger_out = acc_en;
  assign pt_count    = pt_count_reg;

endmodule
